// File: rtl/bp_common_cfg_link_pkg.sv
// Config-link register map and boot-sequencer state encoding shared by the
// boot master and the per-tile config endpoints.
package bp_common_cfg_link_pkg;

    localparam int unsigned bp_cfg_link_addr_width_gp = 16;

    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_freeze_gp      = 16'h0001;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_core_id_gp     = 16'h0002;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_cce_mode_gp    = 16'h0003;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_mem_ucode_base_gp  = 16'h8000;

    typedef enum logic {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

    typedef enum logic [2:0] {
        e_boot_freeze   = 3'd0,
        e_boot_core_id  = 3'd1,
        e_boot_ucode_rd = 3'd2,
        e_boot_ucode_wr = 3'd3,
        e_boot_mode     = 3'd4,
        e_boot_unfreeze = 3'd5,
        e_boot_done     = 3'd6
    } bp_cfg_boot_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear takes priority and loads the up bit.
module bsg_counter_clear_up #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= width_p'(up_i);
        end else if (up_i) begin
            r_count <= r_count + width_p'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config master: freezes, identifies, loads CCE microcode into and
// sets CCE mode on every core, then unfreezes them all.
module bp_cfg_boot_sequencer
    import bp_common_cfg_link_pkg::*;
#(
    parameter int unsigned num_core_p       = 1,
    parameter int unsigned ucode_els_p      = 256,
    parameter int unsigned cfg_addr_width_p = 16,
    parameter int unsigned cfg_data_width_p = 64,
    parameter int unsigned cce_mode_p       = 1,
    localparam int unsigned core_w_lp  = (num_core_p  > 1) ? $clog2(num_core_p)  : 1,
    localparam int unsigned ucode_w_lp = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic [ucode_w_lp-1:0]       ucode_addr_o,
    input  logic [cfg_data_width_p-1:0] ucode_data_i,
    output logic                        done_o
);

    localparam logic [core_w_lp-1:0]  last_core_lp  = core_w_lp'(num_core_p - 1);
    localparam logic [ucode_w_lp-1:0] last_ucode_lp = ucode_w_lp'(ucode_els_p - 1);

    bp_cfg_boot_state_e r_state, w_state_nxt;

    logic                        r_cfg_v,      w_cfg_v_nxt;
    logic [cfg_addr_width_p-1:0] r_cfg_addr,   w_cfg_addr_nxt;
    logic [cfg_data_width_p-1:0] r_cfg_data,   w_cfg_data_nxt;
    logic                        r_done,       w_done_nxt;
    logic                        r_ucode_cap,  w_ucode_cap_nxt;
    logic [cfg_data_width_p-1:0] r_ucode_data, w_ucode_data_nxt;

    logic                  w_fire;
    logic                  w_load;
    logic                  w_core_clr, w_core_up;
    logic                  w_ucode_clr, w_ucode_up;
    logic [core_w_lp-1:0]  w_core_cnt;
    logic [ucode_w_lp-1:0] w_ucode_cnt;

    assign w_fire = r_cfg_v & cfg_ready_i;

    bsg_counter_clear_up #(.width_p(core_w_lp)) u_core_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_core_clr),
        .up_i    (w_core_up),
        .count_o (w_core_cnt)
    );

    bsg_counter_clear_up #(.width_p(ucode_w_lp)) u_ucode_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_ucode_clr),
        .up_i    (w_ucode_up),
        .count_o (w_ucode_cnt)
    );

    // State register and registered link payload
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= e_boot_freeze;
            r_cfg_v      <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_data   <= '0;
            r_done       <= 1'b0;
            r_ucode_cap  <= 1'b0;
            r_ucode_data <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cfg_v      <= w_cfg_v_nxt;
            r_cfg_addr   <= w_cfg_addr_nxt;
            r_cfg_data   <= w_cfg_data_nxt;
            r_done       <= w_done_nxt;
            r_ucode_cap  <= w_ucode_cap_nxt;
            r_ucode_data <= w_ucode_data_nxt;
        end
    end

    // Next state, counter control, and payload for the beat offered next cycle
    always_comb begin
        w_state_nxt      = r_state;
        w_cfg_v_nxt      = r_cfg_v;
        w_cfg_addr_nxt   = r_cfg_addr;
        w_cfg_data_nxt   = r_cfg_data;
        w_done_nxt       = r_done;
        w_ucode_cap_nxt  = r_ucode_cap;
        w_ucode_data_nxt = r_ucode_data;
        w_load           = 1'b0;
        w_core_clr       = 1'b0;
        w_core_up        = 1'b0;
        w_ucode_clr      = 1'b0;
        w_ucode_up       = 1'b0;

        case (r_state)
            e_boot_freeze: begin
                // Out of reset nothing is on the link yet; present FREEZE first.
                if (!r_cfg_v) begin
                    w_load = 1'b1;
                end else if (w_fire) begin
                    w_state_nxt = e_boot_core_id;
                    w_load      = 1'b1;
                end
            end
            e_boot_core_id: begin
                if (w_fire) begin
                    w_state_nxt = e_boot_ucode_rd;
                    w_ucode_clr = 1'b1;
                    w_load      = 1'b1;
                end
            end
            e_boot_ucode_rd: begin
                w_state_nxt = e_boot_ucode_wr;
                w_load      = 1'b1;
            end
            e_boot_ucode_wr: begin
                // ROM word is taken once; stalled cycles replay the held copy.
                if (!r_ucode_cap) begin
                    w_ucode_data_nxt = ucode_data_i;
                    w_ucode_cap_nxt  = 1'b1;
                end
                if (w_fire) begin
                    w_ucode_cap_nxt = 1'b0;
                    w_load          = 1'b1;
                    if (w_ucode_cnt == last_ucode_lp) begin
                        w_state_nxt = e_boot_mode;
                    end else begin
                        w_state_nxt = e_boot_ucode_rd;
                        w_ucode_up  = 1'b1;
                    end
                end
            end
            e_boot_mode: begin
                if (w_fire) begin
                    w_load = 1'b1;
                    if (w_core_cnt == last_core_lp) begin
                        w_state_nxt = e_boot_unfreeze;
                        w_core_clr  = 1'b1;
                    end else begin
                        w_state_nxt = e_boot_freeze;
                        w_core_up   = 1'b1;
                    end
                end
            end
            e_boot_unfreeze: begin
                if (w_fire) begin
                    w_load = 1'b1;
                    if (w_core_cnt == last_core_lp) begin
                        w_state_nxt = e_boot_done;
                    end else begin
                        w_core_up = 1'b1;
                    end
                end
            end
            e_boot_done: begin
                w_state_nxt = e_boot_done;
            end
            default: begin
                w_state_nxt = e_boot_freeze;
            end
        endcase

        if (w_load) begin
            case (w_state_nxt)
                e_boot_freeze: begin
                    w_cfg_v_nxt    = 1'b1;
                    w_cfg_addr_nxt = cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
                    w_cfg_data_nxt = cfg_data_width_p'(1);
                end
                e_boot_core_id: begin
                    w_cfg_v_nxt    = 1'b1;
                    w_cfg_addr_nxt = cfg_addr_width_p'(bp_cfg_reg_core_id_gp);
                    w_cfg_data_nxt = cfg_data_width_p'(w_core_cnt);
                end
                e_boot_ucode_wr: begin
                    w_cfg_v_nxt    = 1'b1;
                    w_cfg_addr_nxt = cfg_addr_width_p'(bp_cfg_mem_ucode_base_gp)
                                   + cfg_addr_width_p'(w_ucode_cnt);
                    w_cfg_data_nxt = '0;
                end
                e_boot_mode: begin
                    w_cfg_v_nxt    = 1'b1;
                    w_cfg_addr_nxt = cfg_addr_width_p'(bp_cfg_reg_cce_mode_gp);
                    w_cfg_data_nxt = cfg_data_width_p'(cce_mode_p);
                end
                e_boot_unfreeze: begin
                    w_cfg_v_nxt    = 1'b1;
                    w_cfg_addr_nxt = cfg_addr_width_p'(bp_cfg_reg_freeze_gp);
                    w_cfg_data_nxt = '0;
                end
                e_boot_done: begin
                    w_cfg_v_nxt    = 1'b0;
                    w_cfg_addr_nxt = '0;
                    w_cfg_data_nxt = '0;
                    w_done_nxt     = 1'b1;
                end
                default: begin
                    w_cfg_v_nxt    = 1'b0;
                    w_cfg_addr_nxt = '0;
                    w_cfg_data_nxt = '0;
                end
            endcase
        end
    end

    // First UCODE_WR cycle forwards the ROM word as it arrives, later cycles the held copy
    assign cfg_data_o   = (r_state == e_boot_ucode_wr)
                        ? (r_ucode_cap ? r_ucode_data : ucode_data_i)
                        : r_cfg_data;
    assign cfg_v_o      = r_cfg_v;
    assign cfg_core_o   = w_core_cnt;
    assign cfg_addr_o   = r_cfg_addr;
    assign ucode_addr_o = w_ucode_cnt;
    assign done_o       = r_done;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench: two sequencer instances (2 cores x 4 words, 1 core x 1 word)
// checked against a hand-built expected beat list.
module tb_bp_cfg_boot_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rdy;
    logic sel;

    logic        v_a, done_a;
    logic [0:0]  core_a;
    logic [15:0] addr_a;
    logic [63:0] data_a;
    logic [1:0]  uaddr_a;
    logic [63:0] rom_a;

    logic        v_b, done_b;
    logic [0:0]  core_b;
    logic [15:0] addr_b;
    logic [63:0] data_b;
    logic [0:0]  uaddr_b;
    logic [63:0] rom_b;

    logic [63:0] m_v, m_core, m_addr, m_data, m_uaddr, m_done;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] e_core[$];
    logic [63:0] e_addr[$];
    logic [63:0] e_data[$];

    bp_cfg_boot_sequencer #(
        .num_core_p(2), .ucode_els_p(4), .cfg_addr_width_p(16),
        .cfg_data_width_p(64), .cce_mode_p(1)
    ) u_dut_a (
        .clk_i(clk), .reset_i(rst), .cfg_v_o(v_a), .cfg_ready_i(rdy),
        .cfg_core_o(core_a), .cfg_addr_o(addr_a), .cfg_data_o(data_a),
        .ucode_addr_o(uaddr_a), .ucode_data_i(rom_a), .done_o(done_a)
    );

    bp_cfg_boot_sequencer #(
        .num_core_p(1), .ucode_els_p(1), .cfg_addr_width_p(16),
        .cfg_data_width_p(64), .cce_mode_p(1)
    ) u_dut_b (
        .clk_i(clk), .reset_i(rst), .cfg_v_o(v_b), .cfg_ready_i(rdy),
        .cfg_core_o(core_b), .cfg_addr_o(addr_b), .cfg_data_o(data_b),
        .ucode_addr_o(uaddr_b), .ucode_data_i(rom_b), .done_o(done_b)
    );

    // Synchronous microcode ROMs: data valid the cycle after the address
    always_ff @(posedge clk) begin
        rom_a <= 64'hA5A5_0000 + 64'(uaddr_a);
        rom_b <= 64'hA5A5_0000 + 64'(uaddr_b);
    end

    always_comb begin
        if (sel) begin
            m_v = 64'(v_b); m_core = 64'(core_b); m_addr = 64'(addr_b);
            m_data = data_b; m_uaddr = 64'(uaddr_b); m_done = 64'(done_b);
        end else begin
            m_v = 64'(v_a); m_core = 64'(core_a); m_addr = 64'(addr_a);
            m_data = data_a; m_uaddr = 64'(uaddr_a); m_done = 64'(done_a);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int c, input logic [63:0] a, input logic [63:0] d);
        e_core.push_back(64'(c));
        e_addr.push_back(a);
        e_data.push_back(d);
    endtask

    task automatic build_exp(input int nc, input int ne);
        e_core.delete(); e_addr.delete(); e_data.delete();
        for (int c = 0; c < nc; c++) begin
            push_beat(c, 64'h0001, 64'd1);
            push_beat(c, 64'h0002, 64'(c));
            for (int i = 0; i < ne; i++)
                push_beat(c, 64'h8000 + 64'(i), 64'hA5A5_0000 + 64'(i));
            push_beat(c, 64'h0003, 64'd1);
        end
        for (int c = 0; c < nc; c++)
            push_beat(c, 64'h0001, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_v", m_v, 64'd0);
            chk("rst_done", m_done, 64'd0);
        end
        chk("rst_core", m_core, 64'd0);
        chk("rst_addr", m_addr, 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_uaddr", m_uaddr, 64'd0);
        rst = 1'b0;
    endtask

    // Drives ready each negedge and scoreboards every accepted beat
    task automatic run_seq(input int nc, input int ne, input bit rnd, input int abort_at,
                           input int exp_last, input int exp_done, output bit aborted);
        int cyc = 0;
        int idx = 0;
        int rd = 0;
        int last_x = 0;
        int done_c = 0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [63:0] pc, pa, pd;
        pc = '0; pa = '0; pd = '0;
        aborted = 1'b0;
        build_exp(nc, ne);
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("first_v", m_v, 64'd1);
            if (pv && !pr) begin
                chk("stall_v", m_v, 64'd1);
                chk("stall_core", m_core, pc);
                chk("stall_addr", m_addr, pa);
                chk("stall_data", m_data, pd);
            end
            if (m_v == 64'd0 && m_done == 64'd0) begin
                chk("rom_addr", m_uaddr, 64'(rd % ne));
                rd++;
            end
            if (m_done != 64'd0) begin
                done_c = cyc;
                break;
            end
            if (cyc > 2000) begin
                chk("timeout", 64'd0, 64'd1);
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_v != 64'd0 && rdy) begin
                if (idx < e_addr.size()) begin
                    chk($sformatf("beat%0d_core", idx), m_core, e_core[idx]);
                    chk($sformatf("beat%0d_addr", idx), m_addr, e_addr[idx]);
                    chk($sformatf("beat%0d_data", idx), m_data, e_data[idx]);
                end else begin
                    chk("extra_beat", 64'(idx), 64'(e_addr.size()));
                end
                idx++;
                last_x = cyc;
                if (abort_at > 0 && idx == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
            end
            pv = (m_v != 64'd0);
            pr = rdy;
            pc = m_core; pa = m_addr; pd = m_data;
        end
        if (!aborted) begin
            chk("beat_count", 64'(idx), 64'(e_addr.size()));
            chk("rom_reads", 64'(rd), 64'(nc * ne));
            if (exp_done > 0) begin
                chk("last_xfer_cycle", 64'(last_x), 64'(exp_last));
                chk("done_cycle", 64'(done_c), 64'(exp_done));
            end
            repeat (5) begin
                @(negedge clk);
                chk("done_hold", m_done, 64'd1);
                chk("done_idle_v", m_v, 64'd0);
            end
        end
    endtask

    initial begin
        bit ab;
        rst = 1'b1;
        rdy = 1'b1;
        sel = 1'b0;

        // 2 cores x 4 words, ready high: 16 beats, done on cycle 25
        do_reset();
        run_seq(2, 4, 1'b0, 0, 24, 25, ab);

        // Random backpressure
        do_reset();
        run_seq(2, 4, 1'b1, 0, 0, 0, ab);

        // Reset mid-ucode on core 0, then full restart from FREEZE
        do_reset();
        run_seq(2, 4, 1'b0, 5, 0, 0, ab);
        chk("abort_reached", 64'(ab), 64'd1);
        do_reset();
        run_seq(2, 4, 1'b0, 0, 24, 25, ab);

        // Degenerate 1 core x 1 word: done on cycle 7
        sel = 1'b1;
        do_reset();
        run_seq(1, 1, 1'b0, 0, 6, 7, ab);

        // Ready low for 100 cycles: FREEZE held, then complete under random ready
        sel = 1'b0;
        do_reset();
        rdy = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("hold_v", m_v, 64'd1);
            chk("hold_addr", m_addr, 64'h0001);
            chk("hold_data", m_data, 64'd1);
            chk("hold_done", m_done, 64'd0);
        end
        run_seq(2, 4, 1'b1, 0, 0, 0, ab);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
